// File: rtl/keccak_squeeze_unit.sv
// Squeeze-side reader for the Keccak permutation: captures the state on perm_done
// and streams rate lanes out over valid/ready, requesting more permutations as needed.
`timescale 1ns/1ps

package keccak_pkg;
  // state[y][x] is one 64-bit lane; lane index i = 5*y + x
  typedef logic [4:0][4:0][63:0] state;
endpackage

module keccak_squeeze_unit #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] out_lanes,
  input  keccak_pkg::state perm_state,
  input  logic             perm_done,
  output logic             perm_req,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PERM,
    S_OUTPUT,
    S_FINISH
  } fsm_e;

  fsm_e             r_state;
  fsm_e             w_next_state;
  keccak_pkg::state r_buf;
  logic [IDX_W-1:0] r_lane_idx;
  logic [LEN_W-1:0] r_remaining;

  logic             w_xfer;
  logic             w_block_end;
  logic             w_final_beat;
  logic [24:0][63:0] w_lanes;

  // The packed [y][x] layout flattens to lane order 5*y + x, so a flat view indexes lanes directly.
  assign w_lanes      = r_buf;
  assign w_xfer       = (r_state == S_OUTPUT) && dout_ready;
  assign w_block_end  = (r_lane_idx == LAST_IDX);
  assign w_final_beat = (r_remaining == LEN_W'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = (out_lanes != '0) ? S_WAIT_PERM : S_FINISH;
      end
      S_WAIT_PERM: begin
        if (perm_done) w_next_state = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (w_xfer) begin
          if (w_final_beat)     w_next_state = S_FINISH;
          else if (w_block_end) w_next_state = S_WAIT_PERM;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the capture buffer is plain flops, not RAM, so it takes the async reset and
  // no lane from an earlier squeeze can ever appear on dout after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_lane_idx  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (out_lanes != '0)) r_remaining <= out_lanes;
        end
        S_WAIT_PERM: begin
          if (perm_done) begin
            r_buf      <= perm_state;
            r_lane_idx <= '0;
          end
        end
        S_OUTPUT: begin
          if (w_xfer) begin
            if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
            r_lane_idx <= w_block_end ? '0 : r_lane_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    perm_req   = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_WAIT_PERM: busy = 1'b1;
      S_OUTPUT: begin
        busy       = 1'b1;
        dout_valid = 1'b1;
        dout       = w_lanes[r_lane_idx];
        dout_last  = w_final_beat;
        perm_req   = w_xfer && w_block_end && (r_remaining > LEN_W'(1));
      end
      S_FINISH: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Bench for keccak_squeeze_unit: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares every accepted beat.
`timescale 1ns/1ps

module tb_keccak_squeeze_unit;
  import keccak_pkg::*;

  localparam int R     = 17;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] out_lanes = '0;
  state             perm_state = '0;
  logic             perm_done = 1'b0;
  logic             perm_req;
  logic [63:0]      dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             dout_last;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic        req;
  } beat_t;

  beat_t exp_q[$];
  state  blocks[$];
  int    ready_mode = 0;  // 0 always, 1 random, 2 held low, 3 fixed pattern
  int    pidx = 0;
  int    pat[6] = '{1, 0, 0, 1, 0, 1};

  always #5 clk = ~clk;

  keccak_squeeze_unit #(.RATE_LANES(R), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .out_lanes (out_lanes),
    .perm_state(perm_state),
    .perm_done (perm_done),
    .perm_req  (perm_req),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic state rand_state();
    state s;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        s[y][x] = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic state pat_state(input logic [63:0] base);
    state s;
    for (int i = 0; i < 25; i++) s[i / 5][i % 5] = base + 64'(i);
    return s;
  endfunction

  // Reference model: stream position k comes from block k/R, lane k%R of that block.
  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) begin
      beat_t e;
      int b;
      int i;
      b      = k / R;
      i      = k % R;
      e.data = blocks[b][i / 5][i % 5];
      e.last = (k == n - 1);
      e.req  = (i == R - 1) && (k != n - 1);
      exp_q.push_back(e);
    end
  endtask

  // All driving tasks are entered and left 1 ns after a rising edge.
  task automatic pulse_start(input int n, input bit with_done);
    out_lanes = n[LEN_W-1:0];
    start     = 1'b1;
    if (with_done) begin
      perm_state = rand_state();
      perm_done  = 1'b1;
    end
    @(posedge clk); #1;
    start      = 1'b0;
    perm_done  = 1'b0;
    out_lanes  = LEN_W'($urandom());
  endtask

  task automatic give_perm(input state s);
    perm_state = s;
    perm_done  = 1'b1;
    @(posedge clk); #1;
    perm_done  = 1'b0;
    perm_state = rand_state();
  endtask

  task automatic wait_perm_req();
    int c;
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      if (perm_req) break;
      c++;
    end
    check("perm_req_seen", c < 300, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 400);
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_squeeze(input int n, input bit lat);
    int nb;
    int cyc;
    nb = (n + R - 1) / R;
    push_expected(n);
    pulse_start(n, 0);
    if (n == 0) begin
      @(negedge clk);
      check("zero_len_done", done, 1);
      check("zero_len_valid", dout_valid, 0);
      @(negedge clk);
      check("zero_len_done_drop", done, 0);
      @(posedge clk); #1;
      return;
    end
    check("busy_wait", busy, 1);
    for (int b = 0; b < nb; b++) begin
      if (b > 0) wait_perm_req();
      if (!lat) begin
        int d;
        d = $urandom_range(0, 3);
        for (int j = 0; j < d; j++) begin
          @(posedge clk); #1;
        end
      end
      give_perm(blocks[b]);
      if (lat) begin
        @(negedge clk);
        check("first_beat_latency", dout_valid, 1);
      end
    end
    wait_done(cyc);
    if (lat) check("done_latency", cyc, n - (nb - 1) * R);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Sink ready generator
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: dout_ready = 1'b1;
        1: dout_ready = 1'($urandom_range(0, 1));
        2: dout_ready = 1'b0;
        default: begin
          dout_ready = (pidx < 6) ? (pat[pidx] != 0) : 1'b1;
          if (dout_valid) pidx++;
        end
      endcase
    end
  end

  // Monitor: compares accepted beats against the scoreboard and checks hold rules
  initial begin
    logic        prev_stall;
    logic [63:0] prev_dout;
    logic        prev_last;
    prev_stall = 1'b0;
    prev_dout  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", dout_valid, 1);
          check("hold_dout", dout, prev_dout);
          check("hold_last", dout_last, prev_last);
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("dout", dout, e.data);
            check("dout_last", dout_last, e.last);
            check("perm_req", perm_req, e.req);
          end
        end else begin
          check("perm_req_no_xfer", perm_req, 0);
        end
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;

    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_perm_req", perm_req, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single short block at full rate
    ready_mode = 0;
    blocks.delete();
    blocks.push_back(pat_state(64'h1));
    run_squeeze(4, 1);

    // Extended output across two permutations
    blocks.delete();
    blocks.push_back(pat_state(64'h0));
    blocks.push_back(pat_state(64'h100));
    run_squeeze(20, 1);

    // Back-pressure pattern
    ready_mode = 3;
    pidx       = 0;
    blocks.delete();
    blocks.push_back(pat_state(64'h0));
    run_squeeze(3, 0);

    // Zero-length request
    ready_mode = 0;
    blocks.delete();
    run_squeeze(0, 0);

    // Reset on the second beat, then a fresh squeeze
    blocks.delete();
    blocks.push_back(pat_state(64'h500));
    push_expected(8);
    pulse_start(8, 0);
    give_perm(blocks[0]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dout", dout, 0);
    check("rst_mid_valid", dout_valid, 0);
    check("rst_mid_last", dout_last, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_perm_req", perm_req, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    blocks.delete();
    blocks.push_back(pat_state(64'h600));
    run_squeeze(2, 1);

    // start and perm_done during a stalled OUTPUT are ignored
    ready_mode = 2;
    blocks.delete();
    blocks.push_back(pat_state(64'h1));
    push_expected(4);
    pulse_start(4, 0);
    give_perm(blocks[0]);
    out_lanes  = 16'd9;
    start      = 1'b1;
    perm_state = rand_state();
    perm_done  = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    perm_done  = 1'b0;
    @(posedge clk); #1;
    check("ignored_busy", busy, 1);
    check("ignored_dout", dout, 64'h1);
    @(negedge clk);
    ready_mode = 0;
    wait_done(cyc);
    check("ignored_queue_drained", exp_q.size(), 0);

    // perm_done coincident with start is not captured
    blocks.delete();
    blocks.push_back(pat_state(64'h700));
    push_expected(3);
    pulse_start(3, 1);
    @(posedge clk); #1;
    check("same_cycle_still_waiting", dout_valid, 0);
    give_perm(blocks[0]);
    wait_done(cyc);
    check("same_cycle_queue_drained", exp_q.size(), 0);

    // Randomized lengths, data and back-pressure
    ready_mode = 1;
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 45);
      blocks.delete();
      for (int b = 0; b < (n + R - 1) / R; b++) blocks.push_back(rand_state());
      run_squeeze(n, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
